// File: rtl/skinny_cms1_pkg.sv
// Shared types and byte-level helpers for the 2-share CMS SKINNY-128-384+ datapath.
// The bit shuffles are linear, so they are applied to each share independently.
package skinny_cms1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL_A = 2'd1,
    EVAL_B = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  localparam int SKINNY_SBOX8_RW    = 76;
  localparam int SKINNY_STATE_BYTES = 16;
  localparam int SBOX_HALF_RW       = SKINNY_SBOX8_RW / 2;

  // Bit permutation between the NOR/XOR rounds of S8.
  function automatic logic [7:0] sbox_perm(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  // Final output swap of S8: bits 1 and 2 exchange places.
  function automatic logic [7:0] sbox_swap(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

endpackage

// File: rtl/skinny_sbox8_cms1_layer_seq_if.sv
// Bus between the round-state register and the byte-serial S-box layer sequencer.
interface skinny_sbox8_cms1_layer_seq_if
  import skinny_cms1_pkg::*;
#(
  parameter int NBYTES = SKINNY_STATE_BYTES,
  parameter int RW     = SKINNY_SBOX8_RW
);
  logic                  start;
  logic [8*NBYTES-1:0]   s0_in;
  logic [8*NBYTES-1:0]   s1_in;
  logic [RW-1:0]         rnd;
  logic                  rnd_req;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   s0_out;
  logic [8*NBYTES-1:0]   s1_out;

  modport master (output start, s0_in, s1_in, rnd,
                  input  rnd_req, busy, done, s0_out, s1_out);
  modport slave  (input  start, s0_in, s1_in, rnd,
                  output rnd_req, busy, done, s0_out, s1_out);
endinterface

// File: rtl/skinny_sbox8_cms1_rapid_non_pipelined.sv
// Two-share masked SKINNY S8: first register level holds the first two NOR/XOR rounds,
// second level the last two. Input must be held for two edges; registers are not reset.
module skinny_sbox8_cms1_rapid_non_pipelined
  import skinny_cms1_pkg::*;
(
  input  logic                       clk,
  input  logic [7:0]                 si0,
  input  logic [7:0]                 si1,
  input  logic [SKINNY_SBOX8_RW-1:0] r,
  output logic [7:0]                 bo0,
  output logic [7:0]                 bo1
);

  // Cross-domain masks; each vector XORs to zero so the AND result stays intact.
  function automatic logic [3:0] mask3(input logic [2:0] m);
    return {m[0] ^ m[1] ^ m[2], m[2], m[1], m[0]};
  endfunction

  function automatic logic [3:0] mask4(input logic [3:0] m);
    return {m[3] ^ m[0], m[2] ^ m[3], m[1] ^ m[2], m[0] ^ m[1]};
  endfunction

  // Returns {z1, z0} with z0 ^ z1 = (p0 ^ p1) & (q0 ^ q1); share domains kept apart.
  function automatic logic [1:0] and2_masked(input logic p0, input logic p1,
                                             input logic q0, input logic q1,
                                             input logic [3:0] m);
    return {(p1 & q0) ^ m[2] ^ (p1 & q1) ^ m[3],
            (p0 & q0) ^ m[0] ^ (p0 & q1) ^ m[1]};
  endfunction

  // One NOR/XOR round: x0 ^= ~(x3|x2), x4 ^= ~(x7|x6); inversion folded into share 0.
  function automatic logic [15:0] cms_mix(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [3:0] m_lo, input logic [3:0] m_hi);
    logic [1:0] z_lo;
    logic [1:0] z_hi;
    z_lo = and2_masked(~a0[3], a1[3], ~a0[2], a1[2], m_lo);
    z_hi = and2_masked(~a0[7], a1[7], ~a0[6], a1[6], m_hi);
    return {a1 ^ {3'b000, z_hi[1], 3'b000, z_lo[1]},
            a0 ^ {3'b000, z_hi[0], 3'b000, z_lo[0]}};
  endfunction

  function automatic logic [15:0] cms_half(input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [SBOX_HALF_RW-1:0] m,
                                           input logic last);
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [15:0] t;
    a0 = x0 ^ m[7:0];
    a1 = x1 ^ m[7:0];
    t  = cms_mix(a0, a1, mask3(m[10:8]), mask3(m[13:11]));
    a0 = sbox_perm(t[7:0])  ^ m[21:14];
    a1 = sbox_perm(t[15:8]) ^ m[21:14];
    t  = cms_mix(a0, a1, mask4(m[25:22]), mask4(m[29:26]));
    a0 = last ? sbox_swap(t[7:0])  : sbox_perm(t[7:0]);
    a1 = last ? sbox_swap(t[15:8]) : sbox_perm(t[15:8]);
    return {a1 ^ m[37:30], a0 ^ m[37:30]};
  endfunction

  logic [7:0]  mid0;
  logic [7:0]  mid1;
  logic [15:0] half1;
  logic [15:0] half2;

  assign half1 = cms_half(si0, si1, r[SBOX_HALF_RW-1:0], 1'b0);
  assign half2 = cms_half(mid0, mid1, r[SKINNY_SBOX8_RW-1:SBOX_HALF_RW], 1'b1);

  always_ff @(posedge clk) begin
    mid0 <= half1[7:0];
    mid1 <= half1[15:8];
    bo0  <= half2[7:0];
    bo1  <= half2[15:8];
  end

endmodule

// File: rtl/skinny_sbox8_cms1_layer_seq.sv
// Byte-serial S-box layer: holds each state byte for two cycles in the masked S-box
// and reassembles the substituted shares. Shares are never recombined here.
//
//   state  | meaning
//   IDLE   | waiting for start; S-box inputs forced to zero
//   EVAL_A | first cycle of byte k; captures S-box result for byte k-1 (k > 0)
//   EVAL_B | second cycle of byte k; advances k or moves to DRAIN
//   DRAIN  | flushes the last byte and publishes the substituted state
module skinny_sbox8_cms1_layer_seq
  import skinny_cms1_pkg::*;
#(
  parameter int NBYTES = SKINNY_STATE_BYTES,
  parameter int RW     = SKINNY_SBOX8_RW
)
(
  input logic                           clk,
  input logic                           rst_n,
  skinny_sbox8_cms1_layer_seq_if.slave  bus
);

  localparam int            KW     = $clog2(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  seq_state_t          state, state_nxt;
  logic [KW-1:0]       k, k_nxt, cap_idx;
  logic [8*NBYTES-1:0] hold0, hold1, acc0, acc1, acc0_nxt, acc1_nxt, out0, out1;
  logic [7:0]          si0, si1, si0_nxt, si1_nxt, bo0, bo1;
  logic [RW-1:0]       rnd_w;
  logic                done_q;

  assign rnd_w       = bus.rnd;
  assign bus.rnd_req = (state != IDLE);
  assign bus.busy    = (state != IDLE) | done_q;
  assign bus.done    = done_q;
  assign bus.s0_out  = out0;
  assign bus.s1_out  = out1;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    unique case (state)
      IDLE: if (bus.start) begin
        state_nxt = EVAL_A;
        k_nxt     = '0;
      end
      EVAL_A: state_nxt = EVAL_B;
      EVAL_B: if (k == K_LAST) begin
        state_nxt = DRAIN;
      end else begin
        state_nxt = EVAL_A;
        k_nxt     = k + KW'(1);
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The holding registers load on the same edge as byte 0, so byte 0 comes straight from the bus.
  always_comb begin
    si0_nxt = '0;
    si1_nxt = '0;
    if (state_nxt != IDLE) begin
      if (state == IDLE) begin
        si0_nxt = bus.s0_in[7:0];
        si1_nxt = bus.s1_in[7:0];
      end else begin
        si0_nxt = hold0[{k_nxt, 3'b000} +: 8];
        si1_nxt = hold1[{k_nxt, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    acc0_nxt = acc0;
    acc1_nxt = acc1;
    cap_idx  = (state == DRAIN) ? K_LAST : k - KW'(1);
    if ((state == EVAL_A && k != '0) || state == DRAIN) begin
      acc0_nxt[{cap_idx, 3'b000} +: 8] = bo0;
      acc1_nxt[{cap_idx, 3'b000} +: 8] = bo1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      hold0  <= '0;
      hold1  <= '0;
      acc0   <= '0;
      acc1   <= '0;
      out0   <= '0;
      out1   <= '0;
      si0    <= '0;
      si1    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      si0    <= si0_nxt;
      si1    <= si1_nxt;
      acc0   <= acc0_nxt;
      acc1   <= acc1_nxt;
      done_q <= (state == DRAIN);
      if (state == IDLE && bus.start) begin
        hold0 <= bus.s0_in;
        hold1 <= bus.s1_in;
      end
      if (state == DRAIN) begin
        out0 <= acc0_nxt;
        out1 <= acc1_nxt;
      end
    end
  end

  skinny_sbox8_cms1_rapid_non_pipelined u_sbox (
    .clk (clk),
    .si0 (si0),
    .si1 (si1),
    .r   (rnd_w),
    .bo0 (bo0),
    .bo1 (bo1)
  );

endmodule

// File: doc/skinny_sbox8_cms1_layer_seq.md
# skinny_sbox8_cms1_layer_seq

Byte-serial S-box layer sequencer for the 2-share CMS SKINNY-128-384+ datapath. It accepts a 128-bit two-share state and streams each byte through one `skinny_sbox8_cms1_rapid_non_pipelined` instance. It holds every byte stable for the two cycles that instance needs, supplies fresh randomness each cycle, and reassembles the substituted shares. It sits between the round-function state register (upstream, AddRoundTweakey/MixColumns output) and the ShiftRows/next-round logic (downstream).

## Interface
- `NBYTES`, default 16: number of state bytes per layer.
- `RW`, default 76: randomness bits consumed per cycle by the S-box instance.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: start-of-layer strobe; sampled only in IDLE.
- `s0_in` input 8*NBYTES: share 0 of the input state; byte k is `[8k+7:8k]`.
- `s1_in` input 8*NBYTES: share 1 of the input state.
- `rnd` input RW: fresh random bits; consumed on every cycle in which `rnd_req` is high.
- `rnd_req` output 1: high while the S-box registers absorb randomness (EVAL and DRAIN).
- `busy` output 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output 1: one-cycle pulse; `s0_out`/`s1_out` are valid from this cycle.
- `s0_out` output 8*NBYTES: share 0 of the substituted state.
- `s1_out` output 8*NBYTES: share 1 of the substituted state.

## Operation
- The FSM has four states: IDLE, EVAL_A, EVAL_B, DRAIN.
  - IDLE, when `start` is high: latch `s0_in`/`s1_in` into input holding registers, clear byte index `k` to 0, go to EVAL_A.
  - EVAL_A → EVAL_B unconditionally.
  - EVAL_B: if `k == NBYTES-1`, go to DRAIN; else increment `k` and go to EVAL_A.
  - DRAIN → IDLE. Assert `done` in the following IDLE cycle via a registered flag.
- S-box inputs `si0`/`si1`:
  - Byte `k` of the holding registers during EVAL_A and EVAL_B.
  - The last byte during DRAIN.
  - All-zero in IDLE.
  - They are registered, so they change only on state transitions.
- The `r` port of the S-box is driven directly from `rnd`. Randomness is never reused across cycles, and the block never buffers it.
- Capture: on the clock edge that ends each EVAL_A cycle, except the first, and the edge that ends DRAIN, the S-box outputs `{bo1,bo0}` are written into accumulator byte `k-1`, or byte `NBYTES-1` in DRAIN. At that point every output bit has been registered from the held byte; first-level gadgets capture after one edge, second-level after two.
- At the end of DRAIN the accumulator is copied to `s0_out`/`s1_out`. The outputs hold that value until the next `done`.
- Shares are never recombined inside the block.
- `start` while `busy` is ignored. `start` in the `done` cycle is accepted, because the FSM is in IDLE.
- Reset, including mid-layer: FSM to IDLE; `k`, holding registers, accumulator, `s0_out`, `s1_out`, `busy`, `done`, `rnd_req` and `si0`/`si1` all to 0. The S-box internal registers have no reset; their contents are discarded because a new layer re-evaluates from EVAL_A.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Byte k is applied in cycles 2k+1 and 2k+2, and captured at the end of cycle 2k+3.
- DRAIN occupies cycle 2·NBYTES+1.
- `done` occurs in cycle 2·NBYTES+2: cycle 34 for NBYTES=16. Initiation interval is 2·NBYTES+2.
- `rnd_req` is high for exactly 2·NBYTES+1 consecutive cycles per layer: 33 for the default.
- `busy` covers cycles 1 through 2·NBYTES+2.

## Structure
- The shared package `skinny_cms1_pkg` holds:
  - FSM state enum (2-bit encoding).
  - `SKINNY_SBOX8_RW = 76`.
  - `SKINNY_STATE_BYTES = 16`.
- Single sub-module: `skinny_sbox8_cms1_rapid_non_pipelined`, instantiated once.
- Byte mux and capture demux are indexed by `k` (`$clog2(NBYTES)` bits).

## Test plan
- Reset values: hold `rst_n` low, then release → all outputs 0, `busy=0`, `rnd_req=0`.
- All-zero state:
  - Stimulus: `s0_in=s1_in=0`, `rnd` random, pulse `start`.
  - Required: `done` at cycle 34; `s0_out^s1_out` = 0x65 in every byte; `rnd_req` high for exactly 33 cycles.
- Byte-order check:
  - Stimulus: unshared byte k = k (0x00..0x0F); `s1_in` random; `s0_in` = value ^ `s1_in`.
  - Required: each recombined byte equals the SKINNY S8 of its input, e.g. byte 1 = 0x4C, byte 2 = 0x6A; byte 0xFF → 0xFF.
- Randomness independence: same state twice with different `rnd` streams → identical recombined output, different individual shares.
- Mid-layer reset: assert `rst_n` at cycle 15 → next-cycle outputs all 0. A new `start` afterwards yields correct results with no residue.
- Start handling: `start` held high continuously → back-to-back layers, `done` every 34 cycles; a `start` pulse during `busy` is ignored (no extra `done`).
